// File: rtl/reorder_buffer_pkg.sv
// Shared processor definitions for the reorder buffer, hazard detection and dispatch.
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif

package reorder_buffer_pkg;

  localparam int ROB_TAG_W  = $clog2(`ROB_SIZE);
  localparam int ROB_DATA_W = 32;
  localparam int ROB_REG_W  = 5;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [ROB_REG_W-1:0]  rd;
    logic [ROB_DATA_W-1:0] value;
  } rob_entry;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Modulo-SIZE pointer register with increment enable and synchronous clear.
module rob_ptr #(
  parameter int SIZE = 16,
  parameter int W    = $clog2(SIZE)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Pointer advances by one and wraps from SIZE-1 back to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == W'(SIZE - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, tagged writeback, in-order retire.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = `ROB_SIZE,
  parameter int DATA_W   = ROB_DATA_W,
  parameter int REG_W    = ROB_REG_W,
  parameter int TAG_W    = $clog2(ROB_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              retire_stall,
  output logic              retire_valid,
  output logic              retire_we,
  output logic [REG_W-1:0]  retire_rd,
  output logic [DATA_W-1:0] retire_value,
  output rob_entry          rob [ROB_SIZE],
  output int                rob_head,
  output logic              rob_full,
  output logic              rob_empty
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(ROB_SIZE);

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  rob_ptr #(.SIZE(ROB_SIZE), .W(TAG_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (retire_valid),
    .ptr   (head)
  );

  rob_ptr #(.SIZE(ROB_SIZE), .W(TAG_W)) u_tail (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (alloc_ready),
    .ptr   (tail)
  );

  // Occupancy flags come from the registered count, never from pointer comparison.
  always_comb begin
    rob_full  = (count == FULL_CNT);
    rob_empty = (count == '0);
  end

  // Allocation handshake and retire decision, all from registered state.
  always_comb begin
    alloc_ready  = alloc_valid && !rob_full && !flush;
    alloc_tag    = tail;
    retire_valid = rob[head].valid && rob[head].ready && !retire_stall && !flush;
    retire_rd    = rob[head].rd;
    retire_value = rob[head].value;
    retire_we    = retire_valid && (rob[head].rd != '0);
    rob_head     = int'(head);
  end

  // Occupancy count: allocate and retire in the same cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({alloc_ready, retire_valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry array. Later assignments win: a retire clears a head that is
  // written back in the same cycle, and allocation only targets a free slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        rob[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        rob[i].valid <= 1'b0;
        rob[i].ready <= 1'b0;
      end
    end else begin
      if (wb_valid && rob[wb_tag].valid) begin
        rob[wb_tag].ready <= 1'b1;
        rob[wb_tag].value <= wb_value;
      end
      if (retire_valid) begin
        rob[head].valid <= 1'b0;
        rob[head].ready <= 1'b0;
      end
      if (alloc_ready) begin
        rob[tail] <= '{valid: 1'b1, ready: 1'b0, rd: alloc_rd, value: '0};
      end
    end
  end

  // Structural invariants of the buffer.
  a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= FULL_CNT);
  a_retire_nonempty: assert property (@(posedge clk) disable iff (reset) retire_valid |-> !rob_empty);
  a_alloc_notfull: assert property (@(posedge clk) disable iff (reset) alloc_ready |-> !rob_full);

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: reference model + retire scoreboard, vector table, corner sequences.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_tag = '0;
  logic [31:0] wb_value = '0;
  logic        retire_stall = 1'b0;
  logic        retire_valid;
  logic        retire_we;
  logic [4:0]  retire_rd;
  logic [31:0] retire_value;
  rob_entry    rob_arr [N];
  int          rob_head;
  logic        rob_full;
  logic        rob_empty;

  reorder_buffer #(.ROB_SIZE(N), .DATA_W(32), .REG_W(5), .TAG_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .alloc_valid  (alloc_valid),
    .alloc_rd     (alloc_rd),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_value     (wb_value),
    .retire_stall (retire_stall),
    .retire_valid (retire_valid),
    .retire_we    (retire_we),
    .retire_rd    (retire_rd),
    .retire_value (retire_value),
    .rob          (rob_arr),
    .rob_head     (rob_head),
    .rob_full     (rob_full),
    .rob_empty    (rob_empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          mvalid [N];
  bit          mready [N];
  logic [4:0]  mrd    [N];
  logic [31:0] mval   [N];
  int          mhead, mtail, mcount;
  int          tag_q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mvalid[i] = 1'b0;
      mready[i] = 1'b0;
      mrd[i]    = '0;
      mval[i]   = '0;
    end
    mhead = 0;
    mtail = 0;
    mcount = 0;
    tag_q.delete();
  endtask

  // Set inputs shortly after the active edge and let combinational outputs settle.
  task automatic drive(input bit fl, input bit av, input logic [4:0] rd, input bit wv,
                       input logic [3:0] wt, input logic [31:0] wval, input bit st);
    flush = fl;
    alloc_valid = av;
    alloc_rd = rd;
    wb_valid = wv;
    wb_tag = wt;
    wb_value = wval;
    retire_stall = st;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 0, 4'd0, 32'd0, 0);
  endtask

  // Compare against the model, score retirements, clock once, then advance the model.
  task automatic tick();
    bit e_ar, e_rv;
    int t;
    e_ar = alloc_valid && (mcount != N) && !flush;
    e_rv = mvalid[mhead] && mready[mhead] && !retire_stall && !flush;
    check("alloc_ready", alloc_ready, e_ar);
    check("alloc_tag", alloc_tag, mtail);
    check("retire_valid", retire_valid, e_rv);
    check("rob_full", rob_full, mcount == N);
    check("rob_empty", rob_empty, mcount == 0);
    check("rob_head", rob_head, mhead);
    for (int i = 0; i < N; i++) begin
      check("entry_valid", rob_arr[i].valid, mvalid[i]);
      check("entry_ready", rob_arr[i].ready, mready[i]);
    end
    if (e_rv) begin
      if (tag_q.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        t = tag_q.pop_front();
        check("sb_tag_order", t, mhead);
        check("sb_retire_rd", retire_rd, mrd[t]);
        check("sb_retire_value", retire_value, mval[t]);
        check("sb_retire_we", retire_we, mrd[t] != 0);
      end
    end
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        mvalid[i] = 1'b0;
        mready[i] = 1'b0;
      end
      mhead = 0;
      mtail = 0;
      mcount = 0;
      tag_q.delete();
    end else begin
      if (wb_valid && mvalid[wb_tag]) begin
        mready[wb_tag] = 1'b1;
        mval[wb_tag] = wb_value;
      end
      if (e_rv) begin
        mvalid[mhead] = 1'b0;
        mready[mhead] = 1'b0;
        mhead = (mhead + 1) % N;
      end
      if (e_ar) begin
        mvalid[mtail] = 1'b1;
        mready[mtail] = 1'b0;
        mrd[mtail] = alloc_rd;
        mval[mtail] = '0;
        tag_q.push_back(mtail);
        mtail = (mtail + 1) % N;
      end
      mcount = mcount + (e_ar ? 1 : 0) - (e_rv ? 1 : 0);
    end
    #1;
  endtask

  task automatic do_reset();
    flush = 0; alloc_valid = 0; wb_valid = 0; retire_stall = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          av;
    logic [4:0]  rd;
    bit          wv;
    logic [3:0]  wt;
    logic [31:0] wval;
    bit          e_ar;
    logic [3:0]  e_tag;
    bit          e_rv;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    bit          e_empty;
    int          e_head;
  } vec_t;

  function automatic vec_t mk(bit av, logic [4:0] rd, bit wv, logic [3:0] wt, logic [31:0] wval,
                              bit e_ar, logic [3:0] e_tag, bit e_rv, logic [4:0] e_rd,
                              logic [31:0] e_val, bit e_empty, int e_head);
    vec_t v;
    v.av = av; v.rd = rd; v.wv = wv; v.wt = wt; v.wval = wval;
    v.e_ar = e_ar; v.e_tag = e_tag; v.e_rv = e_rv; v.e_rd = e_rd; v.e_val = e_val;
    v.e_empty = e_empty; v.e_head = e_head;
    return v;
  endfunction

  vec_t tbl [9];

  initial begin
    // Out-of-order writeback, in-order retire: first retire one cycle after tag0 writeback
    tbl[0] = mk(1, 5'd1, 0, 4'd0, 32'h0, 1, 4'd0, 0, 5'd0, 32'h0, 1, 0);
    tbl[1] = mk(1, 5'd2, 0, 4'd0, 32'h0, 1, 4'd1, 0, 5'd0, 32'h0, 0, 0);
    tbl[2] = mk(1, 5'd3, 0, 4'd0, 32'h0, 1, 4'd2, 0, 5'd0, 32'h0, 0, 0);
    tbl[3] = mk(0, 5'd0, 1, 4'd2, 32'hC, 0, 4'd3, 0, 5'd0, 32'h0, 0, 0);
    tbl[4] = mk(0, 5'd0, 1, 4'd0, 32'hA, 0, 4'd3, 0, 5'd0, 32'h0, 0, 0);
    tbl[5] = mk(0, 5'd0, 1, 4'd1, 32'hB, 0, 4'd3, 1, 5'd1, 32'hA, 0, 0);
    tbl[6] = mk(0, 5'd0, 0, 4'd0, 32'h0, 0, 4'd3, 1, 5'd2, 32'hB, 0, 1);
    tbl[7] = mk(0, 5'd0, 0, 4'd0, 32'h0, 0, 4'd3, 1, 5'd3, 32'hC, 0, 2);
    tbl[8] = mk(0, 5'd0, 0, 4'd0, 32'h0, 0, 4'd3, 0, 5'd0, 32'h0, 1, 3);

    model_reset();
    #12;
    do_reset();

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 5'(i + 7), 0, 4'd0, 32'd0, 0);
      tick();
    end
    reset = 1'b1;
    #1;
    check("async_reset_empty", rob_empty, 1);
    check("async_reset_head", rob_head, 0);
    check("async_reset_full", rob_full, 0);
    check("async_reset_retire", retire_valid, 0);
    for (int i = 0; i < N; i++) check("async_reset_valid", rob_arr[i].valid, 0);
    reset = 1'b0;
    model_reset();
    drive(0, 1, 5'd4, 0, 4'd0, 32'd0, 0);
    check("post_reset_tag", alloc_tag, 0);
    tick();

    // Table-driven in-order retire
    do_reset();
    for (int r = 0; r < 9; r++) begin
      drive(0, tbl[r].av, tbl[r].rd, tbl[r].wv, tbl[r].wt, tbl[r].wval, 0);
      check("tbl_alloc_ready", alloc_ready, tbl[r].e_ar);
      check("tbl_alloc_tag", alloc_tag, tbl[r].e_tag);
      check("tbl_retire_valid", retire_valid, tbl[r].e_rv);
      check("tbl_empty", rob_empty, tbl[r].e_empty);
      check("tbl_head", rob_head, tbl[r].e_head);
      if (tbl[r].e_rv) begin
        check("tbl_retire_rd", retire_rd, tbl[r].e_rd);
        check("tbl_retire_value", retire_value, tbl[r].e_val);
      end
      tick();
    end

    // Full and wrap
    do_reset();
    for (int i = 0; i < N; i++) begin
      drive(0, 1, 5'(i + 1), 0, 4'd0, 32'd0, 0);
      tick();
    end
    drive(0, 1, 5'd20, 1, 4'd0, 32'h100, 0);
    check("full_flag", rob_full, 1);
    check("full_reject", alloc_ready, 0);
    tick();
    drive(0, 1, 5'd21, 0, 4'd0, 32'd0, 0);
    check("full_retire", retire_valid, 1);
    check("full_retire_reject", alloc_ready, 0);
    tick();
    drive(0, 1, 5'd22, 0, 4'd0, 32'd0, 0);
    check("wrap_accept", alloc_ready, 1);
    check("wrap_tag", alloc_tag, 0);
    tick();
    idle();
    check("wrap_full_again", rob_full, 1);
    check("wrap_head", rob_head, 1);
    tick();

    // Stall holds the head
    do_reset();
    drive(0, 1, 5'd5, 0, 4'd0, 32'd0, 0);
    tick();
    drive(0, 0, 5'd0, 1, 4'd0, 32'h77, 0);
    check("wb_same_cycle_no_retire", retire_valid, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 5'd0, 0, 4'd0, 32'd0, 1);
      check("stall_retire", retire_valid, 0);
      check("stall_head", rob_head, 0);
      tick();
    end
    idle();
    check("unstall_retire", retire_valid, 1);
    check("unstall_rd", retire_rd, 5);
    check("unstall_value", retire_value, 32'h77);
    tick();
    idle();
    check("unstall_head_next", rob_head, 1);
    tick();

    // Flush
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 5'(i + 10), 0, 4'd0, 32'd0, 0);
      tick();
    end
    drive(0, 0, 5'd0, 1, 4'd0, 32'h10, 1);
    tick();
    drive(0, 0, 5'd0, 1, 4'd3, 32'h30, 1);
    tick();
    drive(1, 1, 5'd9, 0, 4'd0, 32'd0, 0);
    check("flush_no_retire", retire_valid, 0);
    check("flush_no_alloc", alloc_ready, 0);
    tick();
    drive(0, 0, 5'd0, 1, 4'd1, 32'h99, 0);
    check("flush_empty", rob_empty, 1);
    check("flush_head", rob_head, 0);
    check("flush_tail", alloc_tag, 0);
    tick();
    idle();
    check("stale_wb_valid", rob_arr[1].valid, 0);
    check("stale_wb_ready", rob_arr[1].ready, 0);
    check("stale_wb_retire", retire_valid, 0);
    tick();

    // rd = 0 retires without a register write
    do_reset();
    drive(0, 1, 5'd0, 0, 4'd0, 32'd0, 0);
    tick();
    drive(0, 0, 5'd0, 1, 4'd0, 32'h55, 0);
    tick();
    idle();
    check("rd0_retire_valid", retire_valid, 1);
    check("rd0_retire_we", retire_we, 0);
    check("rd0_retire_value", retire_value, 32'h55);
    tick();
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
